// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and a
// saturating discard counter. Define PIPE_SKID_EN for a registered-ready skid entry.
module pipe_stage_hs #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              xfer_in;
    logic              xfer_out;
    logic [1:0]        discard_c;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = m_valid && out_ready;

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign flush_cnt = cnt_q;

    // Saturating accumulation of entries discarded by flush.
    assign cnt_sum = SUM_W'(cnt_q) + SUM_W'(discard_c);

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef PIPE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    assign m_valid  = (state_q != ST_EMPTY);
    assign in_ready = in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
        end
    end

    // Next state: M always holds the older entry; S only refills M.
    always_comb begin
        state_d   = state_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        discard_c = 2'(in_valid);
        case (state_q)
            ST_ONE:  discard_c = 2'(2'd1 + 2'(in_valid));
            ST_FULL: discard_c = 2'(2'd2 + 2'(in_valid));
            default: discard_c = 2'(in_valid);
        endcase

        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && out_ready) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (xfer_in) begin
                        state_d  = ST_FULL;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_FULL);
    end

`else

    logic m_valid_q, m_valid_d;

    assign m_valid  = m_valid_q;
    assign in_ready = !m_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    // Flush beats transfer; data is kept so only the control bits form the bubble.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        discard_c = 2'(2'(m_valid_q) + 2'(in_valid));
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
        end else if (xfer_in) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
        end else if (xfer_out) begin
            m_valid_d = 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (base or PIPE_SKID_EN build).
module tb_pipe_stage_hs;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_ctrl;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_ctrl;
    logic [63:0] out_data;
    logic        flush;
    logic [15:0] flush_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [8:0]  out_ctrl2;
    logic [63:0] out_data2;
    logic [1:0]  flush_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_hs dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .flush_cnt(flush_cnt)
    );

    pipe_stage_hs #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
        .flush(flush), .flush_cnt(flush_cnt2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [63:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 9'h0, 64'h0);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_ctrl !== 9'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
        n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 9'(i), 64'(i));
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_ctrl !== 9'(i) || out_data !== 64'(i)) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%0b c=%h d=%h want v=1 c=%h d=%h",
                         i, out_valid, out_ctrl, out_data, 9'(i), 64'(i));
            end
        end
        drive(1'b0, 9'h0, 64'h0);
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h0 || out_data !== 64'd8) begin
            n_fail++;
            $display("FAIL stream_idle got v=%0b c=%h d=%h want v=0 c=0 d=8", out_valid, out_ctrl, out_data);
        end
        n_checks++; if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL stream_flush_cnt got %0d want 0", flush_cnt); end
    endtask

    task automatic test_backpressure();
        logic exp_rdy;
        out_ready = 1'b0;
        drive(1'b1, 9'h5, 64'h5);
        cyc();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 9'h6, 64'h6);
            #1;
            exp_rdy = (SKID && k == 0);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL bp_in_ready_%0d got %0b want %0b", k, in_ready, exp_rdy);
            end
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_ctrl !== 9'h5 || out_data !== 64'h5) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got v=%0b c=%h d=%h want v=1 c=5 d=5", k, out_valid, out_ctrl, out_data);
            end
        end
        out_ready = 1'b1;
        drive(1'b1, 9'h6, 64'h6);
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 9'h6 || out_data !== 64'h6) begin
            n_fail++;
            $display("FAIL bp_drain got v=%0b c=%h d=%h want v=1 c=6 d=6", out_valid, out_ctrl, out_data);
        end
        drive(1'b0, 9'h0, 64'h0);
        cyc();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush_full();
        logic [15:0] exp_cnt;
        exp_cnt = SKID ? 16'd3 : 16'd2;
        out_ready = 1'b0;
        drive(1'b1, 9'h1FF, 64'hDEAD_BEEF);
        cyc();
        if (SKID) begin
            drive(1'b1, 9'h0AA, 64'h2);
            cyc();
        end
        drive(1'b1, 9'h003, 64'h3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 9'h0, 64'h0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_ctrl !== 9'h0) begin n_fail++; $display("FAIL flush_out_ctrl got %h want 0", out_ctrl); end
        n_checks++; if (out_data !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL flush_out_data got %h want deadbeef", out_data); end
        n_checks++; if (flush_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt_full got %0d want %0d", flush_cnt, exp_cnt); end
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        out_ready = 1'b1;
        cyc();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit got %0b want 0", out_valid); end
    endtask

    task automatic test_flush_empty();
        logic [15:0] exp_cnt;
        exp_cnt = SKID ? 16'd3 : 16'd2;
        drive(1'b0, 9'h0, 64'h0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        n_checks++; if (flush_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_empty_cnt got %0d want %0d", flush_cnt, exp_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 9'h11, 64'h11);
            flush = 1'b1;
            cyc();
            exp_sat = (k > 3) ? 2'd3 : 2'(k);
            n_checks++;
            if (flush_cnt2 !== exp_sat) begin
                n_fail++; $display("FAIL sat_cnt_%0d got %0d want %0d", k, flush_cnt2, exp_sat);
            end
            n_checks++;
            if (flush_cnt !== 16'(k)) begin
                n_fail++; $display("FAIL wide_cnt_%0d got %0d want %0d", k, flush_cnt, k);
            end
        end
        flush = 1'b0;
        drive(1'b0, 9'h0, 64'h0);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 9'h0A1, 64'hA1);
        cyc();
        drive(1'b1, 9'h0B2, 64'hB2);
        cyc();
        drive(1'b1, 9'h0C3, 64'hC3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b0, 9'h0, 64'h0);
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 9'h0 || out_data !== 64'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got v=%0b c=%h d=%h cnt=%0d want all 0",
                     out_valid, out_ctrl, out_data, flush_cnt);
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %0b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_leak_%0d got v=%0b d=%h want v=0", k, out_valid, out_data); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_flush_empty();
        test_saturation();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
